// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register and write-back controller
// Every output is taken from a register, so no input has a combinational path to an output.
module mem_wb_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              InValid,
   input  logic [XLEN-1:0]   InResult,
   input  logic [REG_AW-1:0] InRd,
   input  logic              InRegWrite,
   input  logic [XLEN-1:0]   InPC,
   input  logic              DStall,
   input  logic              Flush,
   input  logic              Hold,
   output logic              RegWe,
   output logic [REG_AW-1:0] RegWaddr,
   output logic [XLEN-1:0]   RegWdata,
   output logic              FwdValid,
   output logic [REG_AW-1:0] FwdRd,
   output logic [XLEN-1:0]   FwdData,
   output logic [XLEN-1:0]   WbPC,
   output logic              WbValid,
   output logic [CNT_W-1:0]  InstRetired,
   output logic [CNT_W-1:0]  StallCycles
);

   logic              r_v;
   logic              r_rw;
   logic [REG_AW-1:0] r_rd;
   logic [XLEN-1:0]   r_res;
   logic [XLEN-1:0]   r_pc;
   logic [CNT_W-1:0]  r_inst_retired;
   logic [CNT_W-1:0]  r_stall_cycles;
   logic              w_reg_we;

   // Flush beats Hold, and Hold beats DStall. A flush only drops the valid bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v            <= 1'b0;
         r_rw           <= 1'b0;
         r_rd           <= '0;
         r_res          <= '0;
         r_pc           <= '0;
         r_inst_retired <= '0;
         r_stall_cycles <= '0;
      end else if (Flush) begin
         r_v <= 1'b0;
      end else if (Hold) begin
         r_v <= r_v;
      end else if (DStall) begin
         r_v            <= 1'b0;
         r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end else begin
         r_v   <= InValid;
         r_rw  <= InRegWrite;
         r_rd  <= InRd;
         r_res <= InResult;
         r_pc  <= InPC;
         if (InValid) begin
            r_inst_retired <= r_inst_retired + CNT_W'(1);
         end
      end
   end

   // x0 is hardwired to zero, so a write to it is never issued or forwarded.
   assign w_reg_we    = r_v & r_rw & (r_rd != '0);

   assign RegWe       = w_reg_we;
   assign RegWaddr    = r_rd;
   assign RegWdata    = r_res;
   assign FwdValid    = w_reg_we;
   assign FwdRd       = r_rd;
   assign FwdData     = r_res;
   assign WbValid     = r_v;
   assign WbPC        = r_pc;
   assign InstRetired = r_inst_retired;
   assign StallCycles = r_stall_cycles;

endmodule
